// File: rtl/uart_bus_pkg.sv
// Shared constants and types for the memory-mapped UART responder.
// Register offsets, STATUS/CTRL bit positions and the TX FSM states.
package uart_bus_pkg;

  localparam logic [7:0] UART_DATA   = 8'h00;
  localparam logic [7:0] UART_STATUS = 8'h01;
  localparam logic [7:0] UART_CTRL   = 8'h02;

  localparam int ST_RX_NOT_EMPTY = 0;
  localparam int ST_TX_NOT_FULL  = 1;
  localparam int ST_RX_OVERFLOW  = 2;
  localparam int ST_TX_BUSY      = 3;
  localparam int ST_TX_DROPPED   = 4;

  localparam int CTRL_CLR_RX_OVF  = 0;
  localparam int CTRL_CLR_TX_DROP = 1;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_STROBE,
    TX_GUARD
  } tx_state_t;

endpackage

// File: rtl/uart_bus_responder_fifo.sv
// Byte FIFO with power-of-2 depth, used for both TX and RX queues.
// Pop of an empty FIFO is ignored; push when full succeeds only alongside a pop.
module uart_byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     push,
  input  logic [7:0]               pushData,
  input  logic                     pop,
  output logic [7:0]               popData,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign popData = mem[rd_ptr];

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= pushData;
  end

  // Pointers wrap naturally at DEPTH; count tracks occupancy.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_bus_responder.sv
// CPU-bus UART responder: DATA/STATUS/CTRL window over TX and RX FIFOs.
// Holds address decode, TX strobe FSM, rxready edge detect and sticky flags.
module uart_bus_responder
  import uart_bus_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR    = 16'h7F00,
  parameter int          FIFO_DEPTH   = 8,
  parameter int          GUARD_CYCLES = 2
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [7:0] addressBusHigh,
  input  logic [7:0] addressBusLow,
  input  logic       readNotWrite,
  input  logic [7:0] dataBusOutput,
  output logic [7:0] readData,
  output logic       select,
  output logic [7:0] txdata,
  output logic       txclk,
  input  logic       txready,
  input  logic [7:0] rxdata,
  input  logic       rxready,
  output logic       rxclk
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int GW = $clog2(GUARD_CYCLES + 1);

  logic [15:0] addr;
  logic [15:0] off16;
  logic [7:0]  off;
  logic        hit;
  logic        rd_data;
  logic        wr_data;
  logic        wr_ctrl;

  logic          tx_push;
  logic          tx_pop;
  logic [7:0]    tx_head;
  logic          tx_empty;
  logic          tx_full;
  logic [CW-1:0] tx_count;

  logic          rx_push;
  logic [7:0]    rx_head;
  logic          rx_empty;
  logic          rx_full;
  logic [CW-1:0] rx_count;

  tx_state_t     state;
  logic [GW-1:0] guard_cnt;
  logic          tx_busy;

  logic rxready_d;
  logic new_byte;
  logic rx_drop;
  logic rx_overflow;
  logic tx_dropped;
  logic [7:0] status;

  assign addr    = {addressBusHigh, addressBusLow};
  assign off16   = addr - BASE_ADDR;
  assign hit     = (addr >= BASE_ADDR) && (off16 < 16'd3);
  assign off     = off16[7:0];
  assign select  = hit & readNotWrite;
  assign rd_data = select & (off == UART_DATA);
  assign wr_data = hit & ~readNotWrite & (off == UART_DATA);
  assign wr_ctrl = hit & ~readNotWrite & (off == UART_CTRL);

  assign tx_push  = wr_data & ~tx_full;
  assign tx_pop   = (state == TX_STROBE);
  assign tx_busy  = (state != TX_IDLE);

  assign new_byte = rxready & ~rxready_d;
  assign rx_push  = new_byte;
  assign rx_drop  = new_byte & rx_full & ~rd_data;

  // STATUS image assembled from live FIFO occupancy and sticky flags.
  always_comb begin
    status                  = 8'h00;
    status[ST_RX_NOT_EMPTY] = (rx_count != '0);
    status[ST_TX_NOT_FULL]  = (tx_count != CW'(FIFO_DEPTH));
    status[ST_RX_OVERFLOW]  = rx_overflow;
    status[ST_TX_BUSY]      = tx_busy;
    status[ST_TX_DROPPED]   = tx_dropped;
  end

  // Read mux; zero when off-window or on a write-only offset.
  always_comb begin
    readData = 8'h00;
    if (select) begin
      case (off)
        UART_DATA:   readData = rx_empty ? 8'h00 : rx_head;
        UART_STATUS: readData = status;
        default:     readData = 8'h00;
      endcase
    end
  end

  uart_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk      (clk),
    .nrst     (nrst),
    .push     (tx_push),
    .pushData (dataBusOutput),
    .pop      (tx_pop),
    .popData  (tx_head),
    .empty    (tx_empty),
    .full     (tx_full),
    .count    (tx_count)
  );

  uart_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk      (clk),
    .nrst     (nrst),
    .push     (rx_push),
    .pushData (rxdata),
    .pop      (rd_data),
    .popData  (rx_head),
    .empty    (rx_empty),
    .full     (rx_full),
    .count    (rx_count)
  );

  // TX FSM: strobe one byte out, then hold off for the guard window.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= TX_IDLE;
      guard_cnt <= '0;
      txclk     <= 1'b0;
      txdata    <= 8'h00;
    end else begin
      unique case (state)
        TX_IDLE: begin
          if (!tx_empty && txready) begin
            state  <= TX_STROBE;
            txclk  <= 1'b1;
            txdata <= tx_head;
          end
        end
        TX_STROBE: begin
          state     <= TX_GUARD;
          txclk     <= 1'b0;
          guard_cnt <= '0;
        end
        TX_GUARD: begin
          if (guard_cnt == GW'(GUARD_CYCLES - 1)) begin
            state     <= TX_IDLE;
            guard_cnt <= '0;
          end else begin
            guard_cnt <= guard_cnt + GW'(1);
          end
        end
        default: begin
          state <= TX_IDLE;
          txclk <= 1'b0;
        end
      endcase
    end
  end

  // RX edge detect, acknowledge strobe and sticky error flags.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rxready_d   <= 1'b0;
      rxclk       <= 1'b0;
      rx_overflow <= 1'b0;
      tx_dropped  <= 1'b0;
    end else begin
      rxready_d <= rxready;
      rxclk     <= new_byte;
      if (wr_ctrl && dataBusOutput[CTRL_CLR_RX_OVF])  rx_overflow <= 1'b0;
      if (wr_ctrl && dataBusOutput[CTRL_CLR_TX_DROP]) tx_dropped  <= 1'b0;
      if (rx_drop)             rx_overflow <= 1'b1;
      if (wr_data && tx_full)  tx_dropped  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_bus_responder.sv
// Self-checking bench for uart_bus_responder.
// Directed scenarios plus random bus/UART traffic against a queue model.
module tb_uart_bus_responder;

  localparam logic [15:0] BASE = 16'h7F00;
  localparam int DEPTH = 8;
  localparam int G     = 2;

  logic       clk = 1'b0;
  logic       nrst;
  logic [7:0] hi, lo, wdata, rxdata;
  logic       rnw, txready, rxready;
  logic [7:0] read_data, txdata;
  logic       select, txclk, rxclk;

  uart_bus_responder #(
    .BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .GUARD_CYCLES(G)
  ) dut (
    .clk(clk), .nrst(nrst),
    .addressBusHigh(hi), .addressBusLow(lo),
    .readNotWrite(rnw), .dataBusOutput(wdata),
    .readData(read_data), .select(select),
    .txdata(txdata), .txclk(txclk), .txready(txready),
    .rxdata(rxdata), .rxready(rxready), .rxclk(rxclk)
  );

  always #5 clk = ~clk;

  // staged stimulus, applied at each negedge
  logic [15:0] s_addr;
  logic        s_rnw;
  logic [7:0]  s_wdata, s_rxdata;
  logic        s_txready, s_rxready;

  // reference model
  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  bit m_txdrop, m_rxovf, m_prev_rx, m_rxclk;
  int since;
  int cyc;
  int strobe_cyc[$];
  logic [7:0] strobe_dat[$];
  logic [7:0] stat_log[int];
  int rxclk_cnt;
  logic [7:0] last_rd;
  logic last_sel;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    txq.delete();
    rxq.delete();
    m_txdrop = 0;
    m_rxovf = 0;
    m_prev_rx = 0;
    m_rxclk = 0;
    since = 100;
  endtask

  task automatic cycle();
    bit hit, busy, pop, nb;
    logic [15:0] off;
    logic [7:0] exp_rd, st;
    @(negedge clk);
    hi = s_addr[15:8];
    lo = s_addr[7:0];
    rnw = s_rnw;
    wdata = s_wdata;
    txready = s_txready;
    rxready = s_rxready;
    rxdata = s_rxdata;
    #1;
    cyc++;
    hit = (s_addr >= BASE) && (s_addr < BASE + 16'd3);
    off = s_addr - BASE;
    if (txclk) since = 0;
    busy = (since <= G);
    if (txclk) begin
      chk("tx_has_byte", 32'(txq.size() != 0), 1);
      if (txq.size() != 0) chk("txdata", txdata, txq[0]);
      strobe_cyc.push_back(cyc);
      strobe_dat.push_back(txdata);
    end
    chk("rxclk", rxclk, m_rxclk);
    if (rxclk) rxclk_cnt++;
    st = {3'b0, m_txdrop, busy, m_rxovf,
          txq.size() < DEPTH, rxq.size() > 0};
    exp_rd = 8'h00;
    if (hit && s_rnw) begin
      if (off == 0) exp_rd = (rxq.size() > 0) ? rxq[0] : 8'h00;
      else if (off == 1) exp_rd = st;
    end
    chk("select", select, hit && s_rnw);
    chk("readData", read_data, exp_rd);
    last_rd = read_data;
    last_sel = select;
    stat_log[cyc] = st;
    // effects at the coming posedge
    pop = hit && s_rnw && off == 0 && rxq.size() > 0;
    if (hit && !s_rnw && off == 2) begin
      if (s_wdata[0]) m_rxovf = 0;
      if (s_wdata[1]) m_txdrop = 0;
    end
    if (hit && !s_rnw && off == 0) begin
      if (txq.size() == DEPTH) begin
        m_txdrop = 1;
        if (txclk) void'(txq.pop_front());
      end else begin
        if (txclk && txq.size() != 0) void'(txq.pop_front());
        txq.push_back(s_wdata);
      end
    end else if (txclk && txq.size() != 0) begin
      void'(txq.pop_front());
    end
    nb = s_rxready && !m_prev_rx;
    if (pop) void'(rxq.pop_front());
    if (nb) begin
      if (rxq.size() < DEPTH) rxq.push_back(s_rxdata);
      else m_rxovf = 1;
    end
    m_rxclk = nb;
    m_prev_rx = s_rxready;
    if (since < 100) since++;
  endtask

  task automatic idle(input int n);
    s_addr = 16'h0000;
    s_rnw = 1;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wr(input logic [15:0] o, input logic [7:0] d);
    s_addr = BASE + o;
    s_rnw = 0;
    s_wdata = d;
    cycle();
    s_addr = 16'h0000;
    s_rnw = 1;
  endtask

  task automatic rd(input logic [15:0] o);
    s_addr = BASE + o;
    s_rnw = 1;
    cycle();
    s_addr = 16'h0000;
  endtask

  task automatic rx_byte(input logic [7:0] b);
    s_rxready = 1;
    s_rxdata = b;
    cycle();
    s_rxready = 0;
    cycle();
  endtask

  initial begin
    int c0, n0;
    bit seen;
    s_addr = 0; s_rnw = 1; s_wdata = 0;
    s_txready = 0; s_rxready = 0; s_rxdata = 0;
    hi = 0; lo = 0; rnw = 1; wdata = 0;
    txready = 0; rxready = 0; rxdata = 0;
    cyc = 0; rxclk_cnt = 0;
    model_reset();
    nrst = 0;
    #12;
    chk("rst_txclk", txclk, 0);
    chk("rst_rxclk", rxclk, 0);
    chk("rst_txdata", txdata, 0);
    chk("rst_sel_off", select, 0);
    chk("rst_rd_off", read_data, 0);
    @(negedge clk);
    nrst = 1;

    rd(1);
    chk("status_reset", last_rd, 8'h02);
    chk("status_sel", last_sel, 1);

    // two-byte transmit with guard spacing
    s_txready = 0;
    wr(0, 8'hA5);
    wr(0, 8'h3C);
    strobe_cyc.delete();
    strobe_dat.delete();
    s_txready = 1;
    s_addr = BASE + 1;
    s_rnw = 1;
    for (int i = 0; i < 12; i++) cycle();
    chk("tx2_count", strobe_cyc.size(), 2);
    if (strobe_cyc.size() == 2) begin
      chk("tx2_first", strobe_dat[0], 8'hA5);
      chk("tx2_second", strobe_dat[1], 8'h3C);
      chk("tx2_spacing", strobe_cyc[1] - strobe_cyc[0], G + 2);
      c0 = strobe_cyc[0];
      for (int k = 1; k <= G; k++)
        chk("tx2_gap_busy", stat_log[c0 + k][3], 1);
    end

    // overfill TX, then clear tx_dropped
    s_txready = 0;
    idle(2);
    for (int i = 1; i <= 9; i++) wr(0, 8'(i));
    rd(1);
    chk("txfull_status", last_rd, 8'h10);
    wr(2, 8'h02);
    rd(1);
    chk("txdrop_clear", last_rd[4], 0);
    strobe_dat.delete();
    strobe_cyc.delete();
    s_txready = 1;
    idle(8 * (G + 2) + 6);
    chk("txdrain_count", strobe_dat.size(), 8);
    for (int i = 0; i < 8 && i < strobe_dat.size(); i++)
      chk("txdrain_byte", strobe_dat[i], 8'(i + 1));

    // RX overflow scenario
    s_txready = 0;
    n0 = rxclk_cnt;
    for (int i = 0; i < 9; i++) rx_byte(8'h11 + 8'(i));
    idle(1);
    chk("rxclk_pulses", rxclk_cnt - n0, 9);
    rd(1);
    chk("rxfull_status", last_rd, 8'h07);
    for (int i = 0; i < 8; i++) begin
      rd(0);
      chk("rx_read", last_rd, 8'h11 + 8'(i));
    end
    rd(0);
    chk("rx_empty_read", last_rd, 8'h00);
    rd(1);
    chk("rx_empty_bit0", last_rd[0], 0);
    wr(2, 8'h01);

    // full RX with a coincident pop accepts the new byte
    for (int i = 0; i < 8; i++) rx_byte(8'h60 + 8'(i));
    s_addr = BASE;
    s_rnw = 1;
    s_rxready = 1;
    s_rxdata = 8'h77;
    cycle();
    chk("coinc_pop", last_rd, 8'h60);
    s_rxready = 0;
    idle(1);
    rd(1);
    chk("coinc_no_ovf", last_rd[2], 0);
    for (int i = 0; i < 8; i++) rd(0);
    chk("coinc_last", last_rd, 8'h77);

    // reset while strobing
    s_txready = 0;
    wr(0, 8'hC1);
    wr(0, 8'hC2);
    s_txready = 1;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      cycle();
      if (txclk) seen = 1;
    end
    chk("strobe_seen", seen, 1);
    nrst = 0;
    #1;
    chk("rst_mid_txclk", txclk, 0);
    model_reset();
    s_txready = 0;
    @(negedge clk);
    nrst = 1;
    rd(1);
    chk("rst_mid_status", last_rd, 8'h02);

    // random traffic against the model
    for (int i = 0; i < 800; i++) begin
      int r;
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2: s_addr = BASE;
        3, 4:    s_addr = BASE + 16'd1;
        5:       s_addr = BASE + 16'd2;
        6:       s_addr = BASE + 16'd3;
        7:       s_addr = BASE - 16'd1;
        default: s_addr = 16'($urandom);
      endcase
      s_rnw = 1'($urandom);
      s_wdata = 8'($urandom);
      s_txready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) s_rxready = ~s_rxready;
      s_rxdata = 8'($urandom);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
